ewb_queue: RTL and testbench

- Parametrised multi-entry eviction write buffer between the L2 cache and physical memory.
- Absorbs L2 dirty-line writebacks into a DEPTH-entry FIFO so the write completes in one cycle.
- Serves L2 line reads from buffered entries when the address matches; other reads go to memory ahead of pending writebacks.
- Coalesces repeat writebacks to the same line, and drains entries to memory oldest-first whenever the memory port is idle.

---
 rtl/ewb_pkg.sv | 16 +
 rtl/ewb_match.sv | 38 +++
 rtl/ewb_queue.sv | 160 ++++++++++++++++
 tb/tb_ewb_queue.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ewb_pkg.sv
// Shared types and helpers for the eviction write buffer.
package ewb_pkg;

  // Memory-side sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } mem_state_t;

  // Width of a head/tail pointer into a DEPTH-entry ring (DEPTH is a power of two).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ewb_match.sv
// Youngest-first address matcher over the buffered entries.
// Scans from head towards tail so the last hit found is the youngest one.
module ewb_match
  import ewb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic [ADDR_W-1:0]            req_adr,
  input  logic [DEPTH-1:0]             ent_vld,
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_adr,
  input  logic [PTR_W-1:0]             head,
  input  mem_state_t                   state,
  output logic                         hit,
  output logic [PTR_W-1:0]             index,
  output logic                         mergeable
);

  logic [PTR_W-1:0] idx;

  // Walk entries oldest to youngest; a later hit overrides an earlier one.
  always_comb begin
    hit   = 1'b0;
    index = head;
    idx   = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (ent_vld[idx] && (ent_adr[idx] == req_adr)) begin
        hit   = 1'b1;
        index = idx;
      end
    end
    // The head being written to memory right now must not change under the transfer.
    mergeable = hit && !((index == head) && (state == ST_DRAIN));
  end

endmodule

// File: rtl/ewb_queue.sv
// Eviction write buffer between L2 and memory: absorbs writebacks into a FIFO,
// serves matching reads from the buffer, coalesces repeat writebacks, and
// drains oldest-first whenever the memory port is free. Read misses bypass
// pending writebacks.
module ewb_queue
  import ewb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       l2_adr,
  input  logic [DATA_W-1:0]       l2_dat_m,
  input  logic                    l2_we,
  input  logic                    l2_stb,
  input  logic                    l2_cyc,
  output logic [DATA_W-1:0]       l2_dat_s,
  output logic                    l2_ack,
  output logic [ADDR_W-1:0]       mem_adr,
  output logic [DATA_W-1:0]       mem_dat_m,
  output logic                    mem_we,
  output logic                    mem_stb,
  output logic                    mem_cyc,
  output logic [DATA_W/8-1:0]     mem_sel,
  input  logic [DATA_W-1:0]       mem_dat_s,
  input  logic                    mem_ack,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t                     ent [DEPTH];
  logic [PTR_W-1:0]           head, tail;
  mem_state_t                 state;
  logic                       miss_pend;
  logic [ADDR_W-1:0]          miss_adr;
  logic                       ack_p1;
  logic [DATA_W-1:0]          dat_p1;

  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_adr;
  logic                         hit, mergeable;
  logic [PTR_W-1:0]             hit_idx;
  logic accept_ok, wr_merge, wr_push, rd_hit, rd_miss, retire, fill_done;

  // Flatten entry tags for the matcher.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i] = ent[i].valid;
      ent_adr[i] = ent[i].addr;
    end
  end

  ewb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_match (
    .req_adr   (l2_adr),
    .ent_vld   (ent_vld),
    .ent_adr   (ent_adr),
    .head      (head),
    .state     (state),
    .hit       (hit),
    .index     (hit_idx),
    .mergeable (mergeable)
  );

  // A request is taken only when no ack is showing and no read miss is outstanding.
  assign accept_ok = l2_stb && l2_cyc && !ack_p1 && !miss_pend && (state != ST_FILL);
  assign wr_merge  = accept_ok &&  l2_we && mergeable;
  assign wr_push   = accept_ok &&  l2_we && !mergeable && !full;
  assign rd_hit    = accept_ok && !l2_we && hit;
  assign rd_miss   = accept_ok && !l2_we && !hit;
  assign retire    = (state == ST_DRAIN) && mem_ack;
  assign fill_done = (state == ST_FILL)  && mem_ack;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

  assign l2_ack    = ack_p1 | fill_done;
  assign l2_dat_s  = fill_done ? mem_dat_s : dat_p1;

  assign mem_stb   = (state != ST_IDLE);
  assign mem_cyc   = (state != ST_IDLE);
  assign mem_we    = (state == ST_DRAIN);
  assign mem_adr   = (state == ST_FILL) ? miss_adr : ent[head].addr;
  assign mem_dat_m = ent[head].data;
  assign mem_sel   = '1;

  // Memory sequencer: read misses take priority over draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (miss_pend) state <= ST_FILL;
                  else if (!empty) state <= ST_DRAIN;
        ST_FILL:  if (mem_ack) state <= ST_IDLE;
        ST_DRAIN: if (mem_ack) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (retire) begin
        head <= head + 1'b1;
        ent[head].valid <= 1'b0;
      end
      if (wr_push) begin
        tail <= tail + 1'b1;
        ent[tail].valid <= 1'b1;
        ent[tail].addr  <= l2_adr;
        ent[tail].data  <= l2_dat_m;
      end
      if (wr_merge) ent[hit_idx].data <= l2_dat_m;
      case ({wr_push, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // L2 response registers and the pending read-miss latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_p1    <= 1'b0;
      dat_p1    <= '0;
      miss_pend <= 1'b0;
      miss_adr  <= '0;
    end else begin
      ack_p1 <= wr_merge | wr_push | rd_hit;
      if (rd_hit)         dat_p1 <= ent[hit_idx].data;
      else if (fill_done) dat_p1 <= mem_dat_s;
      if (rd_miss) begin
        miss_pend <= 1'b1;
        miss_adr  <= l2_adr;
      end else if (fill_done) begin
        miss_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ewb_queue.sv
// Scoreboard bench for ewb_queue: stimulus pushes expected L2 responses and
// memory transactions; independent monitors pop and compare them.
module tb_ewb_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 128;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [ADDR_W-1:0]      l2_adr = '0;
  logic [DATA_W-1:0]      l2_dat_m = '0;
  logic                   l2_we = 1'b0;
  logic                   l2_stb = 1'b0;
  logic                   l2_cyc = 1'b0;
  logic [DATA_W-1:0]      l2_dat_s;
  logic                   l2_ack;
  logic [ADDR_W-1:0]      mem_adr;
  logic [DATA_W-1:0]      mem_dat_m;
  logic                   mem_we, mem_stb, mem_cyc;
  logic [DATA_W/8-1:0]    mem_sel;
  logic [DATA_W-1:0]      mem_dat_s = '0;
  logic                   mem_ack = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic                   full, empty;

  always #5 clk = ~clk;

  ewb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .l2_adr(l2_adr), .l2_dat_m(l2_dat_m), .l2_we(l2_we), .l2_stb(l2_stb), .l2_cyc(l2_cyc),
    .l2_dat_s(l2_dat_s), .l2_ack(l2_ack),
    .mem_adr(mem_adr), .mem_dat_m(mem_dat_m), .mem_we(mem_we), .mem_stb(mem_stb),
    .mem_cyc(mem_cyc), .mem_sel(mem_sel), .mem_dat_s(mem_dat_s), .mem_ack(mem_ack),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct { logic rd; logic [DATA_W-1:0] dat; } l2_exp_t;
  typedef struct { logic we; logic [ADDR_W-1:0] adr; logic [DATA_W-1:0] dat; } mem_exp_t;

  l2_exp_t  l2_q[$];
  mem_exp_t mem_q[$];
  l2_exp_t  le;
  mem_exp_t me;
  int errors = 0;
  int checks = 0;
  logic mem_en = 1'b0;
  logic [$clog2(DEPTH):0] cnt_at_ack = '0;

  localparam logic [DATA_W-1:0] DA = {4{32'hDA7A_0010}};
  localparam logic [DATA_W-1:0] DB = {4{32'h0000_B0B0}};
  localparam logic [DATA_W-1:0] DC = {4{32'hC0C0_0030}};
  localparam logic [DATA_W-1:0] DD = {4{32'hDDDD_0030}};
  localparam logic [DATA_W-1:0] DE = {4{32'hEEEE_0050}};
  localparam logic [DATA_W-1:0] DF = {4{32'hFFFF_0051}};
  localparam logic [DATA_W-1:0] DG = {4{32'h6666_00F0}};
  localparam logic [DATA_W-1:0] DH = {4{32'h1234_0060}};
  localparam logic [DATA_W-1:0] DI = {4{32'h5678_0070}};
  localparam logic [DATA_W-1:0] D0 = {4{32'h0F0F_00F0}};

  // Memory read data pattern derived from the address.
  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return {8{4'hA, a}};
  endfunction

  function automatic logic [DATA_W-1:0] wdat(input int i);
    return {4{24'h0B0000, 8'(i)}};
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: acknowledge one cycle after a strobe appears, when enabled.
  always @(posedge clk) begin
    #1;
    if (mem_en && mem_stb && !mem_ack) begin
      mem_ack   = 1'b1;
      mem_dat_s = mem_rd(mem_adr);
    end else begin
      mem_ack   = 1'b0;
    end
  end

  // L2 response monitor.
  always @(negedge clk) begin
    if (rst_n && l2_ack) begin
      if (l2_q.size() == 0) chk("l2_unexpected_ack", 1'b1, 1'b0);
      else begin
        le = l2_q.pop_front();
        chk("l2_ack_kind", !l2_we, le.rd);
        if (le.rd) chk("l2_rd_data", l2_dat_s, le.dat);
      end
    end
  end

  // Memory transaction monitor.
  always @(negedge clk) begin
    if (rst_n && mem_stb && mem_ack) begin
      if (mem_q.size() == 0) chk("mem_unexpected_access", 1'b1, 1'b0);
      else begin
        me = mem_q.pop_front();
        chk("mem_we", mem_we, me.we);
        chk("mem_adr", mem_adr, me.adr);
        chk("mem_cyc", mem_cyc, 1'b1);
        if (me.we) chk("mem_dat_m", mem_dat_m, me.dat);
      end
    end
  end

  task automatic mexp(input logic we, input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] dat);
    mem_exp_t e;
    e.we = we; e.adr = adr; e.dat = dat;
    mem_q.push_back(e);
  endtask

  task automatic l2_issue(input logic we, input logic [ADDR_W-1:0] adr,
                          input logic [DATA_W-1:0] dat, input logic [DATA_W-1:0] exp_rd);
    l2_exp_t e;
    e.rd = !we; e.dat = exp_rd;
    @(posedge clk); #1;
    l2_q.push_back(e);
    l2_we = we; l2_adr = adr; l2_dat_m = dat; l2_stb = 1'b1; l2_cyc = 1'b1;
  endtask

  task automatic l2_wait(input int maxc);
    logic got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      if (l2_ack) begin got = 1'b1; cnt_at_ack = count; end
    end
    chk("l2_ack_timeout", got, 1'b1);
    @(posedge clk); #1;
    l2_stb = 1'b0; l2_cyc = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] dat);
    l2_issue(1'b1, adr, dat, '0);
    l2_wait(20);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] exp);
    l2_issue(1'b0, adr, '0, exp);
    l2_wait(50);
  endtask

  task automatic wait_drain(input int maxc);
    logic done;
    done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk);
      if (empty && !mem_stb && mem_q.size() == 0) done = 1'b1;
    end
    chk("drain_timeout", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_l2_ack", l2_ack, 0);
    chk("rst_mem_stb", mem_stb, 0);
    chk("rst_mem_cyc", mem_cyc, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_l2_dat_s", l2_dat_s, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_mem_dat_m", mem_dat_m, 0);
    chk("mem_sel_ones", mem_sel, 16'hFFFF);
    rst_n = 1'b1;

    // Single writeback, then drain.
    wr(12'h010, DA);
    chk("t1_count", count, 1);
    chk("t1_empty", empty, 0);
    @(negedge clk);
    chk("t1_drain_stb", mem_stb, 1);
    chk("t1_drain_we", mem_we, 1);
    chk("t1_drain_adr", mem_adr, 12'h010);
    mexp(1'b1, 12'h010, DA);
    mem_en = 1'b1;
    wait_drain(50);
    chk("t1_count_after", count, 0);
    chk("t1_empty_after", empty, 1);
    mem_en = 1'b0;

    // Fill the buffer with memory held busy; the fifth write stalls until a retire.
    for (int i = 0; i < 4; i++) wr(12'h100 + 12'(i), wdat(i));
    chk("t2_count_full", count, 4);
    chk("t2_full", full, 1);
    l2_issue(1'b1, 12'h104, wdat(4), '0);
    repeat (5) begin
      @(negedge clk);
      chk("t2_stall_no_ack", l2_ack, 0);
    end
    chk("t2_count_hold", count, 4);
    for (int i = 0; i < 5; i++) mexp(1'b1, 12'h100 + 12'(i), wdat(i));
    mem_en = 1'b1;
    l2_wait(20);
    chk("t2_count_at_accept", cnt_at_ack, 4);
    wait_drain(100);
    mem_en = 1'b0;

    // Coalescing: 0x0F0 occupies the in-flight head, so 0x020 merges behind it,
    // while a repeat to the draining head is queued as a new entry.
    wr(12'h0F0, D0);
    wr(12'h020, DA);
    wr(12'h020, DB);
    chk("t3_count_merged", count, 2);
    wr(12'h0F0, DG);
    chk("t3_count_no_merge_head", count, 3);
    mexp(1'b1, 12'h0F0, D0);
    mexp(1'b1, 12'h020, DB);
    mexp(1'b1, 12'h0F0, DG);
    mem_en = 1'b1;
    wait_drain(100);
    mem_en = 1'b0;

    // Read hits served from the buffer, youngest match first.
    wr(12'h030, DC);
    rd(12'h030, DC);
    chk("t4_count_after_hit", count, 1);
    wr(12'h030, DD);
    chk("t4_count_two", count, 2);
    rd(12'h030, DD);
    chk("t4_no_mem_read", mem_we, 1);
    mexp(1'b1, 12'h030, DC);
    mexp(1'b1, 12'h030, DD);
    mem_en = 1'b1;
    wait_drain(100);
    mem_en = 1'b0;

    // Read miss bypasses the remaining queued writebacks.
    wr(12'h050, DE);
    wr(12'h051, DF);
    l2_issue(1'b0, 12'h040, '0, mem_rd(12'h040));
    repeat (3) @(negedge clk);
    mexp(1'b1, 12'h050, DE);
    mexp(1'b0, 12'h040, '0);
    mexp(1'b1, 12'h051, DF);
    mem_en = 1'b1;
    l2_wait(50);
    wait_drain(100);
    mexp(1'b0, 12'h041, '0);
    rd(12'h041, mem_rd(12'h041));
    wait_drain(50);
    mem_en = 1'b0;

    // Reset while draining discards buffered data.
    wr(12'h060, DH);
    @(negedge clk);
    chk("t6_drain_active", mem_stb, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_stb", mem_stb, 0);
    chk("t6_async_cyc", mem_cyc, 0);
    chk("t6_async_we", mem_we, 0);
    chk("t6_async_count", count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_count_after", count, 0);
    chk("t6_empty_after", empty, 1);
    chk("t6_stb_after", mem_stb, 0);
    mem_en = 1'b1;
    mexp(1'b1, 12'h070, DI);
    wr(12'h070, DI);
    wait_drain(50);

    repeat (3) @(negedge clk);
    chk("l2_queue_left", l2_q.size(), 0);
    chk("mem_queue_left", mem_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
